mult_accum: RTL
===============

Name: mult_accum

Overview:
- Sequential accumulate stage directly downstream of the combinational unsigned array multiplier.
- Consumes one (N+M)-bit product per accepted beat and sums a frame of products into a wider accumulator.
- Presents the frame result with a term count and status flags on a valid/ready output handshake.
- Used as the reduction stage for dot products built from the multiplier array.

Parameters:
- N, 16, multiplicand width of the upstream multiplier.
- M, 16, multiplier width of the upstream multiplier.
- ACC_W, 40, accumulator/result width; must be >= N+M.
- MAX_TERMS, 8, maximum beats per frame; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- p  input  N+M  unsigned product from the multiplier.
- p_valid  input  1  p is valid this cycle.
- p_last  input  1  final beat of the frame; qualified by p_valid.
- p_ready  output  1  stage can accept a beat.
- acc_out  output  ACC_W  frame sum.
- cnt_out  output  $clog2(MAX_TERMS+1)  number of beats summed in the frame.
- ovf  output  1  sum saturated during the frame.
- trunc  output  1  frame was closed by MAX_TERMS, not by p_last.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.

Behaviour:
- Decided interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values: p_ready=0 while rst is high, then 1 in the first cycle after release. acc_out=0, cnt_out=0, ovf=0, trunc=0, out_valid=0. State=ACC; internal acc and cnt cleared.
- FSM has two states, ACC and DONE.
- ACC:
  - p_ready=1 and out_valid=0.
  - A beat is accepted when p_valid && p_ready.
  - On accept: acc <= sat(acc + zero-extended p); cnt <= cnt+1.
  - ovf becomes sticky-set if the true sum exceeds 2^ACC_W-1; acc then holds all-ones.
- Frame close, ACC to DONE:
  - Closes on an accepted beat with p_last=1, or on the accepted beat that makes cnt equal MAX_TERMS.
  - trunc=1 only when the close is caused by the count and p_last=0.
  - Both conditions in the same beat give trunc=0.
  - The closing beat is included in acc_out and cnt_out.
- DONE:
  - p_ready=0 and out_valid=1.
  - acc_out, cnt_out, ovf and trunc are held stable until out_ready=1.
  - On out_valid && out_ready: next cycle returns to ACC with acc, cnt, ovf, trunc and out_valid cleared.
  - No beat is accepted in the handoff cycle, giving a one-cycle bubble between frames.
- Latency: out_valid rises on the clock edge that accepts the closing beat, so it is high in the following cycle.
- Throughput: one beat per cycle within a frame; minimum two cycles per single-beat frame.
- p_last without p_valid is ignored. p_valid is ignored while in DONE.
- Arithmetic:
  - Unsigned throughout; p is zero-extended to ACC_W+1 bits for the add.
  - Saturation is decided on the carry out of bit ACC_W-1.
- Reset mid-frame: the partial sum is discarded immediately (asynchronous) and no out_valid is produced for that frame.

Optional Feature:
- MACC_CLEAR_EN defined: adds input port clr (1 bit, synchronous, active-high).
  - In any state clr=1 returns to ACC next cycle with acc, cnt and flags zeroed and out_valid=0.
  - A beat presented in the same cycle as clr is dropped; p_ready is forced 0 while clr=1.
  - clr has priority over out_ready and over frame close.
- MACC_CLEAR_EN undefined: no clr port; the only ways to clear are rst or out_ready handoff.

Test Plan:
- Four beats p=0xFFFE0001, last on the 4th, out_ready=1 -> one cycle later acc_out=0x3FFF80004, cnt_out=4, ovf=0, trunc=0, out_valid pulses for 1 cycle.
- ACC_W=32; two beats p=0xFFFE0001, last on the 2nd -> acc_out=0xFFFFFFFF, ovf=1, cnt_out=2.
- Eight beats p=1 with p_last=0 -> close on the 8th beat: acc_out=8, cnt_out=8, trunc=1; a 9th beat is stalled (p_ready=0) until handoff.
- Single beat p=5, last=1, out_ready held 0 for 5 cycles -> out_valid stays 1, acc_out stays 5, p_ready stays 0. After out_ready=1, the next frame p=7/last gives acc_out=7, ovf=0.
- Three beats p=10 accepted, then rst pulsed mid-frame -> out_valid never asserted; the next frame p=3/last gives acc_out=3, cnt_out=1.
- With MACC_CLEAR_EN: two beats p=9, then clr=1 while p_valid=1 -> the beat is dropped; the next frame p=4/last gives acc_out=4, cnt_out=1.

Source files
------------

// File: rtl/mult_accum.sv
// mult_accum: frame accumulator placed after the unsigned array multiplier.
//
// Sums one (N+M)-bit product per accepted beat into an ACC_W-bit saturating
// accumulator. A frame closes on p_last or after MAX_TERMS beats. The sum,
// beat count and status flags are then offered on a valid/ready handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   clr        (only with MACC_CLEAR_EN) synchronous clear, active-high
//   p          product from the multiplier (N+M bits, unsigned)
//   p_valid    p is valid this cycle
//   p_last     final beat of the frame (qualified by p_valid)
//   p_ready    stage can accept a beat
//   acc_out    frame sum (ACC_W bits, saturating)
//   cnt_out    number of beats summed in the frame
//   ovf        sum saturated during the frame
//   trunc      frame closed by MAX_TERMS rather than p_last
//   out_valid  result valid
//   out_ready  downstream accepts the result
//
// Optional feature: define MACC_CLEAR_EN to add the clr input.

module mult_accum #(
  parameter int N         = 16,
  parameter int M         = 16,
  parameter int ACC_W     = 40,
  parameter int MAX_TERMS = 8,
  localparam int CW       = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MACC_CLEAR_EN
  input  logic             clr,
`endif
  input  logic [N+M-1:0]   p,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [CW-1:0]    cnt_out,
  output logic             ovf,
  output logic             trunc,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACC = 1'b0, DONE = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic             armed;
  logic             clr_int;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             ovf_r;
  logic             trunc_r;

  logic             accept;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic [CW-1:0]    cnt_inc;
  logic             hit_max;
  logic             close;
  logic             handoff;

`ifdef MACC_CLEAR_EN
  assign clr_int = clr;
`else
  assign clr_int = 1'b0;
`endif

  // One extra bit on the add: its carry out is the saturation decision.
  assign accept  = p_valid && p_ready;
  assign sum     = {1'b0, acc} + {{(ACC_W + 1 - N - M){1'b0}}, p};
  assign carry   = sum[ACC_W];
  assign cnt_inc = cnt + CW'(1);
  assign hit_max = (cnt_inc == CW'(MAX_TERMS));
  assign close   = accept && (p_last || hit_max);
  assign handoff = (state == DONE) && out_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= next_state;
    end
  end

  // p_ready stays low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Next-state logic; a clear wins over both frame close and handoff.
  always_comb begin
    next_state = state;
    if (clr_int) begin
      next_state = ACC;
    end else begin
      case (state)
        ACC: begin
          if (close) begin
            next_state = DONE;
          end else begin
            next_state = ACC;
          end
        end
        DONE: begin
          if (out_ready) begin
            next_state = ACC;
          end else begin
            next_state = DONE;
          end
        end
        default: next_state = ACC;
      endcase
    end
  end

  // Handshake outputs are decoded from registered state only (plus clr mask).
  always_comb begin
    p_ready   = (state == ACC) && armed && !clr_int;
    out_valid = (state == DONE);
  end

  // Accumulator datapath: cleared on clr or handoff, updated on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= {ACC_W{1'b0}};
      cnt     <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      trunc_r <= 1'b0;
    end else if (clr_int || handoff) begin
      acc     <= {ACC_W{1'b0}};
      cnt     <= {CW{1'b0}};
      ovf_r   <= 1'b0;
      trunc_r <= 1'b0;
    end else if (accept) begin
      acc     <= carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
      cnt     <= cnt_inc;
      ovf_r   <= ovf_r | carry;
      // A count close with p_last set is an ordinary close, not a truncation.
      trunc_r <= hit_max && !p_last;
    end
  end

  assign acc_out = acc;
  assign cnt_out = cnt;
  assign ovf     = ovf_r;
  assign trunc   = trunc_r;

endmodule
